// File: rtl/spi_write.sv
// spi_write: byte-wide SPI transmitter (mode 0, MSB first, active-high CS).
// Each accepted byte is shifted out on mosi with sclk low for CLK_DIV cycles
// and high for CLK_DIV cycles per bit; done pulses in the last high cycle.
// Optional feature macro: SPI_WRITE_BURST_EN -- when defined, a new byte can be
// accepted in the done cycle and streams back-to-back with CS held high.
// Without it every byte is its own frame followed by a 2*CLK_DIV cycle gap.
module spi_write #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       CS,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DIV_W  = 8;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic               sclk_q,  sclk_d;
    logic               mosi_q,  mosi_d;
    logic               cs_q,    cs_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               rdy_q,   rdy_d;
    logic               accept;

    assign accept = tx_valid && rdy_q;

    // State, datapath and registered outputs; synchronous reset clears all
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next state plus bit timing: divider, bit counter, shifter, sclk and mosi
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (accept) begin
                    shift_d = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD, ST_SHIFT: begin
                // LOAD is the first low cycle of bit 7
                state_d = ST_SHIFT;
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            mosi_d  = 1'b0;
                            state_d = ST_GAP;
`ifdef SPI_WRITE_BURST_EN
                            if (accept) begin
                                shift_d = tx_data;
                                mosi_d  = tx_data[DATA_W-1];
                                state_d = ST_LOAD;
                            end
`endif
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            mosi_d  = shift_q[DATA_W-2];
                            shift_d = {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                // two divider periods, bit_q marks the second one
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (div_q == DIV_MAX) begin
                    div_d = '0;
                    if (bit_q == '0) begin
                        bit_d = BIT_W'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered output values derived from the upcoming state
    always_comb begin
        cs_d   = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_SHIFT) && sclk_d && (bit_d == LAST_BIT) &&
                 (div_d == DIV_MAX);
        rdy_d  = (state_d == ST_IDLE);
`ifdef SPI_WRITE_BURST_EN
        rdy_d  = rdy_d || done_d;
`endif
    end

    assign tx_ready = rdy_q;
    assign CS       = cs_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_write.sv
// Bench for spi_write: instance a (CLK_DIV=2) is watched by a scoreboard
// monitor that rebuilds bytes from mosi at sclk rising edges and frame lengths
// from CS; instance b (CLK_DIV=1) covers the fastest divider setting.
module tb_spi_write;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, CS, sclk, mosi, busy, done;
    logic [7:0] tx_data1 = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, cs1, sclk1, mosi1, busy1, done1;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         len_q[$];

    // per-cycle log: bit0 CS, 1 sclk, 2 mosi, 3 done, 4 busy, 5 tx_ready
    logic [5:0] lg  [0:127];
    logic [5:0] lg1 [0:127];

    spi_write #(.CLK_DIV(2)) u_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .CS(CS), .sclk(sclk), .mosi(mosi),
        .busy(busy), .done(done)
    );

    spi_write #(.CLK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .CS(cs1), .sclk(sclk1), .mosi(mosi1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int cnt(input bit inst, input int b, input int a, input int z);
        int c = 0;
        for (int k = a; k <= z; k++) begin
            if (inst ? lg1[k][b] : lg[k][b]) c++;
        end
        return c;
    endfunction

    function automatic int first(input bit inst, input int b, input int a, input int z);
        for (int k = a; k <= z; k++) begin
            if (inst ? lg1[k][b] : lg[k][b]) return k;
        end
        return -1;
    endfunction

    // cycle 0: byte offered to instance a while tx_ready is high
    task automatic start_a(input logic [7:0] d);
        @(negedge clk);
        chk("a_ready_at_offer", int'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
    endtask

    task automatic start_b(input logic [7:0] d);
        @(negedge clk);
        chk("b_ready_at_offer", int'(tx_ready1), 1);
        tx_data1  = d;
        tx_valid1 = 1'b1;
    endtask

    // log cycles 1..n, applying mid-frame stimulus changes after sampling
    task automatic run(input int n, input int drop_at, input int chg_at,
                       input logic [7:0] chg_d, input int rst_at);
        for (int k = 0; k < 128; k++) begin
            lg[k]  = '0;
            lg1[k] = '0;
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            lg[k]  = {tx_ready, busy, done, mosi, sclk, CS};
            lg1[k] = {tx_ready1, busy1, done1, mosi1, sclk1, cs1};
            if (k == drop_at) begin
                tx_valid  = 1'b0;
                tx_valid1 = 1'b0;
            end
            if (k == chg_at) tx_data = chg_d;
            if (k == rst_at) rst = 1'b1;
            else if (k == rst_at + 1) rst = 1'b0;
        end
    endtask

    // scoreboard monitor for instance a
    logic [7:0] m_sh = 8'h00;
    int         m_nb = 0;
    int         m_len = 0;
    logic       m_unst = 1'b0;
    logic       sclk_p = 1'b0;
    logic       mosi_p = 1'b0;
    logic       cs_p = 1'b0;

    always @(negedge clk) begin
        if (sclk && !sclk_p && CS) begin
            m_sh = {m_sh[6:0], mosi};
            m_nb++;
        end
        if (sclk && sclk_p && (mosi != mosi_p)) m_unst = 1'b1;
        if (CS) m_len++;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL byte_unexpected actual=%0h expected=none", m_sh);
            end else begin
                chk("byte_value", int'(m_sh), int'(exp_q.pop_front()));
            end
            chk("bits_per_byte", m_nb, 8);
            chk("mosi_stable_high", int'(m_unst), 0);
            m_nb   = 0;
            m_unst = 1'b0;
        end
        if (!CS && cs_p) begin
            if (len_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_unexpected actual=%0d expected=none", m_len);
            end else begin
                chk("frame_len", m_len, len_q.pop_front());
            end
            m_len  = 0;
            m_nb   = 0;
            m_unst = 1'b0;
        end
        sclk_p = sclk;
        mosi_p = mosi;
        cs_p   = CS;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("a_reset_outputs", int'({CS, sclk, mosi, done, busy, tx_ready}), 0);
        chk("b_reset_outputs", int'({cs1, sclk1, mosi1, done1, busy1, tx_ready1}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("a_ready_after_reset", int'(tx_ready), 1);
        chk("b_ready_after_reset", int'(tx_ready1), 1);

        // single byte 0xA5
        exp_q.push_back(8'hA5);
        len_q.push_back(32);
        start_a(8'hA5);
        run(40, 1, -1, 8'h00, -1);
        chk("a5_cs_high_1_32", cnt(0, 0, 1, 32), 32);
        chk("a5_cs_low_gap", cnt(0, 0, 33, 36), 0);
        chk("a5_done_cycle", first(0, 3, 1, 40), 32);
        chk("a5_done_count", cnt(0, 3, 1, 40), 1);
        chk("a5_ready_low_frame", cnt(0, 5, 1, 36), 0);
        chk("a5_ready_return", first(0, 5, 1, 40), 37);
        chk("a5_busy_frame", cnt(0, 4, 1, 36), 36);
        chk("a5_mosi_idle", cnt(0, 2, 33, 40), 0);
        chk("a5_sclk_edges", cnt(0, 1, 1, 40), 16);

        // byte in flight unaffected by tx_data change
        exp_q.push_back(8'hF0);
        len_q.push_back(32);
        start_a(8'hF0);
        run(40, 1, 5, 8'h00, -1);
        chk("f0_done_cycle", first(0, 3, 1, 40), 32);

        // 0x3C then 0xFF with tx_valid held
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
`ifdef SPI_WRITE_BURST_EN
        len_q.push_back(64);
        start_a(8'h3C);
        run(80, 33, 1, 8'hFF, -1);
        chk("burst_cs_high", cnt(0, 0, 1, 64), 64);
        chk("burst_done1", first(0, 3, 1, 80), 32);
        chk("burst_done2", first(0, 3, 33, 80), 64);
        chk("burst_cs_gap", cnt(0, 0, 65, 68), 0);
        chk("burst_ready_back", first(0, 5, 33, 80), 69);
`else
        len_q.push_back(32);
        len_q.push_back(32);
        start_a(8'h3C);
        run(80, 38, 1, 8'hFF, -1);
        chk("pair_cs_frame1", cnt(0, 0, 1, 32), 32);
        chk("pair_cs_gap", cnt(0, 0, 33, 36), 0);
        chk("pair_ready_low", cnt(0, 5, 1, 36), 0);
        chk("pair_ready_back", first(0, 5, 1, 80), 37);
        chk("pair_cs_frame2", cnt(0, 0, 38, 69), 32);
        chk("pair_done2", first(0, 3, 33, 80), 69);
`endif

        // reset during 0x81 frame
        len_q.push_back(10);
        start_a(8'h81);
        run(20, 1, -1, 8'h00, 10);
        chk("abort_pins_zero", int'(lg[11][2:0]), 0);
        chk("abort_busy", int'(lg[11][4]), 0);
        chk("abort_no_done", cnt(0, 3, 1, 20), 0);
        chk("abort_ready", first(0, 5, 1, 20), 12);

        // CLK_DIV=1 with 0x00
        start_b(8'h00);
        run(20, 1, -1, 8'h00, -1);
        begin
            int bad = 0;
            for (int k = 1; k <= 16; k++) begin
                if (lg1[k][1] != ((k % 2) == 0)) bad++;
            end
            chk("div1_sclk_toggle", bad, 0);
        end
        chk("div1_cs_len", cnt(1, 0, 1, 20), 16);
        chk("div1_cs_drop", int'(lg1[17][0]), 0);
        chk("div1_mosi_zero", cnt(1, 2, 1, 20), 0);
        chk("div1_done", first(1, 3, 1, 20), 16);

        repeat (2) @(negedge clk);
        chk("bytes_left", exp_q.size(), 0);
        chk("frames_left", len_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
